// File: rtl/instr_issue_queue.sv
// Instruction staging FIFO with debounced LOAD/STEP buttons and auto-run issue.
// Each issued instruction is presented once and held until the register stage takes it.
//
// state   | meaning
// IDLE    | nothing presented; waits for a trigger with a non-empty FIFO
// PRESENT | head entry on N1/N2/op/WE with issue_valid=1 until issue_ready
module instr_issue_queue #(
  parameter int DEPTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 50000000
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic [4:0] sw_N1,
  input  logic [4:0] sw_N2,
  input  logic [1:0] sw_op,
  input  logic       sw_WE,
  input  logic       btn_load,
  input  logic       btn_step,
  input  logic       run,
  input  logic       issue_ready,
  output logic       issue_valid,
  output logic [4:0] N1,
  output logic [4:0] N2,
  output logic [1:0] op,
  output logic       WE,
  output logic [4:0] fifo_count,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RCW = $clog2(RUN_DIV + 1);
  localparam logic [DCW-1:0] DB_LAST    = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0] RUN_LAST   = RCW'(RUN_DIV - 1);
  localparam logic [4:0]     COUNT_FULL = 5'(DEPTH);

  typedef enum logic {IDLE, PRESENT} state_t;

  // Bit 0 is LOAD, bit 1 is STEP.
  logic [1:0]     w_btn;
  logic [1:0]     r_sync1, r_sync2, r_db, r_pulse;
  logic [DCW-1:0] r_dcnt [2];

  logic [RCW-1:0] r_run_cnt;
  logic           r_tick;

  logic [12:0]    r_mem [DEPTH];
  logic [AW-1:0]  r_wptr, r_rptr;
  logic [4:0]     r_count;
  logic           r_overflow;

  state_t         r_state;
  logic           r_valid;
  logic [4:0]     r_n1, r_n2;
  logic [1:0]     r_op;
  logic           r_we_hold;

  logic           w_load_p, w_trig, w_empty, w_full, w_pop, w_push;
  logic [12:0]    w_entry, w_head;

  assign w_btn = {btn_step, btn_load};

  // The counter only runs while the synchronised input disagrees with the
  // accepted level, so any bounce back restarts the stability window.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_pulse <= '0;
      for (int i = 0; i < 2; i++) r_dcnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        r_pulse[i] <= 1'b0;
        if (r_sync2[i] == r_db[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == DB_LAST) begin
          r_db[i]    <= r_sync2[i];
          r_dcnt[i]  <= '0;
          r_pulse[i] <= r_sync2[i];
        end else begin
          r_dcnt[i] <= r_dcnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset || !run) begin
      r_run_cnt <= '0;
      r_tick    <= 1'b0;
    end else if (r_run_cnt == RUN_LAST) begin
      r_run_cnt <= '0;
      r_tick    <= 1'b1;
    end else begin
      r_run_cnt <= r_run_cnt + 1'b1;
      r_tick    <= 1'b0;
    end
  end

  assign w_load_p = r_pulse[0];
  assign w_trig   = r_pulse[1] | r_tick;
  assign w_empty  = (r_count == 5'd0);
  assign w_full   = (r_count == COUNT_FULL);
  assign w_pop    = (r_state == IDLE) && w_trig && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push   = w_load_p && (!w_full || w_pop);
  assign w_entry  = {sw_N1, sw_N2, sw_op, sw_WE};
  assign w_head   = r_mem[r_rptr];

  always_ff @(posedge CLK100MHZ) begin
    if (w_push) r_mem[r_wptr] <= w_entry;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_state    <= IDLE;
      r_valid    <= 1'b0;
      r_n1       <= '0;
      r_n2       <= '0;
      r_op       <= '0;
      r_we_hold  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_load_p && !w_push) r_overflow <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_pop) begin
            {r_n1, r_n2, r_op, r_we_hold} <= w_head;
            r_valid <= 1'b1;
            r_state <= PRESENT;
          end
        end
        PRESENT: begin
          if (issue_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign issue_valid = r_valid;
  assign N1          = r_n1;
  assign N2          = r_n2;
  assign op          = r_op;
  assign WE          = r_we_hold & r_valid;
  assign fifo_count  = r_count;
  assign full        = w_full;
  assign empty       = w_empty;
  assign overflow    = r_overflow;

endmodule
